// File: rtl/fp_operand_streamer.sv
// fp_operand_streamer
//
// AXI-Stream initiator for the floating_point_0 multiplier IP. Holds input/weight
// operand pairs in two local buffers, streams them on the A and B channels while
// observing tready, and forwards each returned product tagged with its pair index.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   wr_en/wr_addr/wr_input/wr_weight
//                            operand pair write (ignored while busy)
//   start, len               begin streaming len pairs from address 0 (ignored while busy)
//   m_axis_a_*               channel A (input operand) master
//   m_axis_b_*               channel B (weight operand) master
//   s_axis_result_*          product stream from the IP (tready = busy)
//   result_valid/data/idx    1-cycle pulse with registered product and arrival index
//   busy, done               job in progress / 1-cycle end-of-job pulse
//   timeout                  sticky drain watchdog flag
//
// Optional feature: define FP_STREAM_TIMEOUT_EN to build the drain watchdog. Without it
// timeout is tied low and DRAIN waits indefinitely for the outstanding products.

module fp_operand_streamer #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_input,
  input  logic [DATA_WIDTH-1:0] wr_weight,

  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,

  output logic                  m_axis_a_tvalid,
  input  logic                  m_axis_a_tready,
  output logic [DATA_WIDTH-1:0] m_axis_a_tdata,
  output logic                  m_axis_b_tvalid,
  input  logic                  m_axis_b_tready,
  output logic [DATA_WIDTH-1:0] m_axis_b_tdata,

  input  logic                  s_axis_result_tvalid,
  output logic                  s_axis_result_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_result_tdata,

  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic [ADDR_WIDTH-1:0] result_idx,

  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] IdxOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CntW-1:0]       CntOne = {{(CntW-1){1'b0}}, 1'b1};

  // Reject configurations that cannot work at elaboration time.
  if (ADDR_WIDTH < 1 || DATA_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("fp_operand_streamer: ADDR_WIDTH, DATA_WIDTH and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSend,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Operand buffers (no reset on the arrays; contents undefined after reset).
  logic [DATA_WIDTH-1:0] mem_a [Depth];
  logic [DATA_WIDTH-1:0] mem_b [Depth];

  logic [ADDR_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [CntW-1:0]       len_q, len_d;
  logic [CntW-1:0]       sent_q, sent_d;
  logic [CntW-1:0]       rcvd_q, rcvd_d;

  logic                  a_valid_q, a_valid_d;
  logic                  b_valid_q, b_valid_d;
  logic [DATA_WIDTH-1:0] a_data_q, b_data_q;

  logic                  res_valid_q;
  logic [DATA_WIDTH-1:0] res_data_q;
  logic [ADDR_WIDTH-1:0] res_idx_q;

  logic busy_int;
  logic wr_fire;
  logic rd_fire;
  logic res_accept;
  logic wd_expire;

  assign busy_int   = (state_q == StFetch) || (state_q == StSend) || (state_q == StDrain);
  assign wr_fire    = wr_en && !busy_int;
  assign res_accept = busy_int && s_axis_result_tvalid;

  // ---------------------------------------------------------------------------
  // Drain watchdog
  // ---------------------------------------------------------------------------
`ifdef FP_STREAM_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdOne  = {{(WdW-1){1'b0}}, 1'b1};
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;

  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    wd_expire = 1'b0;
    if (state_q == StIdle && start) begin
      timeout_d = 1'b0;
    end
    // Counts only DRAIN cycles with nothing accepted; the job completing normally
    // in the same cycle takes priority over expiry.
    if (state_q != StDrain || res_accept || rcvd_q == len_q) begin
      wd_d = '0;
    end else if (wd_q == WdLast) begin
      wd_d      = '0;
      wd_expire = 1'b1;
      timeout_d = 1'b1;
    end else begin
      wd_d = wd_q + WdOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rd_idx_d  = rd_idx_q;
    len_d     = len_q;
    sent_d    = sent_q;
    rcvd_d    = res_accept ? (rcvd_q + CntOne) : rcvd_q;
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;
    rd_fire   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          len_d    = len;
          rd_idx_d = '0;
          sent_d   = '0;
          rcvd_d   = '0;
          state_d  = (len == '0) ? StDone : StFetch;
        end
      end

      StFetch: begin
        // Buffer read issued now; data and both tvalids appear together next cycle.
        rd_fire   = 1'b1;
        a_valid_d = 1'b1;
        b_valid_d = 1'b1;
        state_d   = StSend;
      end

      StSend: begin
        a_valid_d = a_valid_q && !m_axis_a_tready;
        b_valid_d = b_valid_q && !m_axis_b_tready;
        if (!a_valid_d && !b_valid_d) begin
          sent_d = sent_q + CntOne;
          if (sent_d == len_q) begin
            state_d = StDrain;
          end else begin
            rd_idx_d = rd_idx_q + IdxOne;
            state_d  = StFetch;
          end
        end
      end

      StDrain: begin
        if (rcvd_q == len_q || wd_expire) begin
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rd_idx_q    <= '0;
      len_q       <= '0;
      sent_q      <= '0;
      rcvd_q      <= '0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      a_data_q    <= '0;
      b_data_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      len_q       <= len_d;
      sent_q      <= sent_d;
      rcvd_q      <= rcvd_d;
      a_valid_q   <= a_valid_d;
      b_valid_q   <= b_valid_d;
      res_valid_q <= res_accept;
      if (rd_fire) begin
        a_data_q <= mem_a[rd_idx_q];
        b_data_q <= mem_b[rd_idx_q];
      end
      if (res_accept) begin
        res_data_q <= s_axis_result_tdata;
        res_idx_q  <= rcvd_q[ADDR_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_a[wr_addr] <= wr_input;
      mem_b[wr_addr] <= wr_weight;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // tdata comes straight from the read registers, which only change in FETCH,
  // so it is stable for as long as tvalid is held.
  assign m_axis_a_tvalid      = a_valid_q;
  assign m_axis_a_tdata       = a_data_q;
  assign m_axis_b_tvalid      = b_valid_q;
  assign m_axis_b_tdata       = b_data_q;
  assign s_axis_result_tready = busy_int;

  assign result_valid = res_valid_q;
  assign result_data  = res_data_q;
  assign result_idx   = res_idx_q;

  assign busy = busy_int;
  assign done = (state_q == StDone);

endmodule
